// File: rtl/alk_pkg.sv
// Shared ALK definitions: ALPCTL microword codes, class masks and the decode bundle.
package alk_pkg;

  localparam int unsigned ALP_W = 10;

  typedef logic [ALP_W-1:0] alpctl_t;

  localparam alpctl_t ALP_NOP   = 10'h000;
  localparam alpctl_t ALP_MULP  = 10'h279;
  localparam alpctl_t ALP_MULN  = 10'h269;
  localparam alpctl_t ALP_DIVP  = 10'h26C;
  localparam alpctl_t ALP_DIVN  = 10'h27C;
  localparam alpctl_t ALP_REM   = 10'h26A;
  localparam alpctl_t ALP_DIVDA = 10'h27F;
  localparam alpctl_t ALP_DIVDS = 10'h26F;
  localparam alpctl_t ALP_LOOPF = 10'h3F0;

  // Class masks on the upper bits of ALPCTL.
  localparam logic [5:0] ALP_WX_S     = 6'h37;
  localparam logic [5:0] ALP_WX_NOT_S = 6'h36;
  localparam logic [1:0] ALP_LOGIC    = 2'b01;

  typedef struct packed {
    logic mul_l;
    logic div_l;
    logic rem_l;
    logic divdbl_l;
    logic wb_loopf_h;
    logic wx_srot_l;
    logic sub_or_logic_l;
  } alp_dec_t;

  function automatic logic is_muldiv(alpctl_t op);
    return (op == ALP_MULP) || (op == ALP_MULN) || (op == ALP_DIVP) || (op == ALP_DIVN);
  endfunction

endpackage

// File: rtl/alkucdec_decode.sv
// Combinational decode of the latched ALPCTL field into the alkmdsm op strobes.
module alkucdec_decode
  import alk_pkg::*;
(
  input  logic [9:0] alpctl,
  output logic       mul_l,
  output logic       div_l,
  output logic       rem_l,
  output logic       divdbl_l,
  output logic       wb_loopf_h,
  output logic       wx_srot_l,
  output logic       sub_or_logic_l
);

  alp_dec_t dec;

  always_comb begin
    dec                = '1;
    dec.wb_loopf_h     = 1'b0;
    dec.mul_l          = ~((alpctl == ALP_MULP) || (alpctl == ALP_MULN));
    dec.div_l          = ~((alpctl == ALP_DIVP) || (alpctl == ALP_DIVN));
    dec.rem_l          = ~(alpctl == ALP_REM);
    dec.divdbl_l       = ~((alpctl == ALP_DIVDA) || (alpctl == ALP_DIVDS));
    dec.wb_loopf_h     = (alpctl == ALP_LOOPF);
    // 36x and 37x share the upper five bits.
    dec.wx_srot_l      = ~(alpctl[9:5] == ALP_WX_S[5:1]);
    dec.sub_or_logic_l = ~((alpctl[9:4] == ALP_WX_NOT_S) ||
                           (alpctl == ALP_MULN) || (alpctl == ALP_REM) ||
                           (alpctl == ALP_DIVP) || (alpctl == ALP_DIVDS) ||
                           (alpctl[9:8] == ALP_LOGIC));
  end

  assign mul_l          = dec.mul_l;
  assign div_l          = dec.div_l;
  assign rem_l          = dec.rem_l;
  assign divdbl_l       = dec.divdbl_l;
  assign wb_loopf_h     = dec.wb_loopf_h;
  assign wx_srot_l      = dec.wx_srot_l;
  assign sub_or_logic_l = dec.sub_or_logic_l;

endmodule

// File: rtl/alkucdec.sv
// ALPCTL latch and mul/div step sequencer; holds the op and stalls the microsequencer
// until the final loop step of a MUL/DIV.
module alkucdec
  import alk_pkg::*;
#(
  parameter int unsigned MD_STEPS = 32,
  parameter int unsigned CW       = 6
) (
  input  logic          qdclk_l,
  input  logic          reset_h,
  input  logic [9:0]    alpctl_in_h,
  input  logic          alpctl_ld_h,
  input  logic          abort_h,
  output logic [9:0]    alpctl_h,
  output logic          alpctl_mul_l,
  output logic          alpctl_div_l,
  output logic          alpctl_rem_l,
  output logic          alpctl_divdbl_l,
  output logic          alpctl_wb_loopf_h,
  output logic          alpctl_wx_srot_l,
  output logic          alpctl_sub_or_logic_l,
  output logic          md_busy_h,
  output logic          md_last_h,
  output logic          useq_stall_h,
  output logic [CW-1:0] step_cnt_h
);

  alpctl_t       alp_q, alp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          last_c;
  logic          accept_c;

  assign last_c   = busy_q & (cnt_q == CW'(1));
  assign accept_c = ~busy_q | last_c;

  always_ff @(posedge qdclk_l or posedge reset_h) begin
    if (reset_h) begin
      alp_q  <= ALP_NOP;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      alp_q  <= alp_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // Abort beats everything; a new microword is only taken when idle or on the last step.
  always_comb begin
    alp_d  = alp_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (abort_h) begin
      alp_d  = ALP_NOP;
      cnt_d  = '0;
      busy_d = 1'b0;
    end else if (accept_c) begin
      alp_d  = ALP_NOP;
      cnt_d  = '0;
      busy_d = 1'b0;
      if (alpctl_ld_h) begin
        alp_d = alpctl_in_h;
        if (is_muldiv(alpctl_in_h)) begin
          cnt_d  = CW'(MD_STEPS);
          busy_d = 1'b1;
        end
      end
    end else if (cnt_q > CW'(1)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  alkucdec_decode u_decode (
    .alpctl         (alp_q),
    .mul_l          (alpctl_mul_l),
    .div_l          (alpctl_div_l),
    .rem_l          (alpctl_rem_l),
    .divdbl_l       (alpctl_divdbl_l),
    .wb_loopf_h     (alpctl_wb_loopf_h),
    .wx_srot_l      (alpctl_wx_srot_l),
    .sub_or_logic_l (alpctl_sub_or_logic_l)
  );

  assign alpctl_h     = alp_q;
  assign step_cnt_h   = cnt_q;
  assign md_busy_h    = busy_q;
  assign md_last_h    = last_c;
  assign useq_stall_h = busy_q & ~last_c;

endmodule

// File: tb/tb_alkucdec.sv
// Self-checking bench for alkucdec: decode table, hand-built sequencer corners,
// full code sweep and randomized traffic against a behavioural model.
module tb_alkucdec;

  localparam int unsigned MD_STEPS = 32;
  localparam int unsigned CW       = 6;

  logic          qdclk_l;
  logic          reset_h;
  logic [9:0]    alpctl_in_h;
  logic          alpctl_ld_h;
  logic          abort_h;
  logic [9:0]    alpctl_h;
  logic          alpctl_mul_l, alpctl_div_l, alpctl_rem_l, alpctl_divdbl_l;
  logic          alpctl_wb_loopf_h, alpctl_wx_srot_l, alpctl_sub_or_logic_l;
  logic          md_busy_h, md_last_h, useq_stall_h;
  logic [CW-1:0] step_cnt_h;
  logic [6:0]    dut_dec;

  alkucdec #(.MD_STEPS(MD_STEPS), .CW(CW)) dut (
    .qdclk_l               (qdclk_l),
    .reset_h               (reset_h),
    .alpctl_in_h           (alpctl_in_h),
    .alpctl_ld_h           (alpctl_ld_h),
    .abort_h               (abort_h),
    .alpctl_h              (alpctl_h),
    .alpctl_mul_l          (alpctl_mul_l),
    .alpctl_div_l          (alpctl_div_l),
    .alpctl_rem_l          (alpctl_rem_l),
    .alpctl_divdbl_l       (alpctl_divdbl_l),
    .alpctl_wb_loopf_h     (alpctl_wb_loopf_h),
    .alpctl_wx_srot_l      (alpctl_wx_srot_l),
    .alpctl_sub_or_logic_l (alpctl_sub_or_logic_l),
    .md_busy_h             (md_busy_h),
    .md_last_h             (md_last_h),
    .useq_stall_h          (useq_stall_h),
    .step_cnt_h            (step_cnt_h)
  );

  assign dut_dec = {alpctl_mul_l, alpctl_div_l, alpctl_rem_l, alpctl_divdbl_l,
                    alpctl_wb_loopf_h, alpctl_wx_srot_l, alpctl_sub_or_logic_l};

  initial qdclk_l = 1'b0;
  always #5 qdclk_l = ~qdclk_l;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode written straight from the op table: {mul,div,rem,divdbl,loopf,wx,sub}.
  function automatic logic [6:0] ref_dec(input int c);
    logic mul, dv, rm, dbl, lf, wx, sb;
    mul = (c == 'h279) || (c == 'h269);
    dv  = (c == 'h26C) || (c == 'h27C);
    rm  = (c == 'h26A);
    dbl = (c == 'h27F) || (c == 'h26F);
    lf  = (c == 'h3F0);
    wx  = ((c / 16) == 'h36) || ((c / 16) == 'h37);
    sb  = ((c / 16) == 'h36) || (c == 'h269) || (c == 'h26A) || (c == 'h26C) ||
          (c == 'h26F) || ((c / 256) == 1);
    return {~mul, ~dv, ~rm, ~dbl, lf, ~wx, ~sb};
  endfunction

  function automatic bit ref_md(input int c);
    return (c == 'h279) || (c == 'h269) || (c == 'h26C) || (c == 'h27C);
  endfunction

  // Behavioural model: the op held and how many loop steps remain.
  int m_alp;
  int m_cnt;
  bit m_busy;

  task automatic model_reset();
    m_alp = 0; m_cnt = 0; m_busy = 0;
  endtask

  task automatic model_step();
    if (abort_h) begin
      m_alp = 0; m_cnt = 0; m_busy = 0;
    end else if (!m_busy || m_cnt == 1) begin
      if (alpctl_ld_h) begin
        m_alp  = int'(alpctl_in_h);
        m_busy = ref_md(m_alp);
        m_cnt  = m_busy ? MD_STEPS : 0;
      end else begin
        m_alp = 0; m_cnt = 0; m_busy = 0;
      end
    end else if (m_cnt > 1) begin
      m_cnt = m_cnt - 1;
    end
  endtask

  task automatic check_model(input string tag);
    bit m_last;
    m_last = m_busy && (m_cnt == 1);
    chk({tag, ".alpctl"}, 32'(alpctl_h), 32'(m_alp));
    chk({tag, ".cnt"},    32'(step_cnt_h), 32'(m_cnt));
    chk({tag, ".busy"},   32'(md_busy_h), 32'(m_busy));
    chk({tag, ".last"},   32'(md_last_h), 32'(m_last));
    chk({tag, ".stall"},  32'(useq_stall_h), 32'(m_busy && !m_last));
    chk({tag, ".dec"},    32'(dut_dec), 32'(ref_dec(m_alp)));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge qdclk_l);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    logic [9:0] code;
    logic [6:0] dec;
    logic       busy;
  } vec_t;

  vec_t tbl[13];
  int   picks[12];
  int   stall_cycles;

  initial begin
    tbl[0]  = '{10'h000, 7'b1111011, 1'b0};
    tbl[1]  = '{10'h279, 7'b0111011, 1'b1};
    tbl[2]  = '{10'h269, 7'b0111010, 1'b1};
    tbl[3]  = '{10'h26C, 7'b1011010, 1'b1};
    tbl[4]  = '{10'h27C, 7'b1011011, 1'b1};
    tbl[5]  = '{10'h26A, 7'b1101010, 1'b0};
    tbl[6]  = '{10'h27F, 7'b1110011, 1'b0};
    tbl[7]  = '{10'h26F, 7'b1110010, 1'b0};
    tbl[8]  = '{10'h3F0, 7'b1111111, 1'b0};
    tbl[9]  = '{10'h365, 7'b1111000, 1'b0};
    tbl[10] = '{10'h37A, 7'b1111001, 1'b0};
    tbl[11] = '{10'h150, 7'b1111010, 1'b0};
    tbl[12] = '{10'h2FF, 7'b1111011, 1'b0};
    picks = '{'h279, 'h269, 'h26C, 'h27C, 'h26A, 'h27F, 'h26F, 'h3F0, 'h365, 'h37A, 'h150, 'h000};

    reset_h = 1'b1; alpctl_in_h = '0; alpctl_ld_h = 1'b0; abort_h = 1'b0;
    model_reset();
    #3;
    chk("reset.alpctl", 32'(alpctl_h), 32'h000);
    chk("reset.dec",    32'(dut_dec), 32'h7B);
    chk("reset.busy",   32'(md_busy_h), 32'h0);
    chk("reset.stall",  32'(useq_stall_h), 32'h0);
    chk("reset.cnt",    32'(step_cnt_h), 32'h0);
    @(posedge qdclk_l); #1;
    @(posedge qdclk_l); #3;
    reset_h = 1'b0;
    @(posedge qdclk_l); #1;

    // Decode table, each op loaded on its own and then cleared by abort.
    for (int i = 0; i < 13; i++) begin
      alpctl_in_h = tbl[i].code; alpctl_ld_h = 1'b1; abort_h = 1'b0;
      tick("tbl");
      chk("tbl.alpctl", 32'(alpctl_h), 32'(tbl[i].code));
      chk("tbl.dec",    32'(dut_dec), 32'(tbl[i].dec));
      chk("tbl.busy",   32'(md_busy_h), 32'(tbl[i].busy));
      alpctl_ld_h = 1'b0; abort_h = 1'b1;
      tick("tbl_abort");
      abort_h = 1'b0;
    end

    // MULP through to its last step, then the next microword is taken.
    alpctl_in_h = 10'h279; alpctl_ld_h = 1'b1;
    tick("mulp");
    chk("mulp.setup_cnt",   32'(step_cnt_h), 32'd32);
    chk("mulp.setup_busy",  32'(md_busy_h), 32'h1);
    chk("mulp.setup_stall", 32'(useq_stall_h), 32'h1);
    stall_cycles = 1;
    alpctl_ld_h = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      tick("mulp_loop");
      chk("mulp.cnt", 32'(step_cnt_h), 32'(32 - k));
      if (useq_stall_h) stall_cycles++;
    end
    chk("mulp.last",        32'(md_last_h), 32'h1);
    chk("mulp.last_stall",  32'(useq_stall_h), 32'h0);
    chk("mulp.stall_total", 32'(stall_cycles), 32'd31);
    alpctl_in_h = 10'h3F0; alpctl_ld_h = 1'b1;
    tick("mulp_next");
    chk("mulp.next_alpctl", 32'(alpctl_h), 32'h3F0);
    chk("mulp.next_busy",   32'(md_busy_h), 32'h0);
    chk("mulp.next_loopf",  32'(alpctl_wb_loopf_h), 32'h1);

    // DIVN then DIVP back to back with no NOP gap.
    alpctl_in_h = 10'h27C; alpctl_ld_h = 1'b1;
    tick("b2b");
    alpctl_ld_h = 1'b0;
    repeat (31) tick("b2b_loop");
    chk("b2b.last", 32'(md_last_h), 32'h1);
    alpctl_in_h = 10'h26C; alpctl_ld_h = 1'b1;
    tick("b2b_second");
    chk("b2b.alpctl", 32'(alpctl_h), 32'h26C);
    chk("b2b.cnt",    32'(step_cnt_h), 32'd32);
    chk("b2b.busy",   32'(md_busy_h), 32'h1);
    chk("b2b.stall",  32'(useq_stall_h), 32'h1);
    alpctl_ld_h = 1'b0; abort_h = 1'b1;
    tick("b2b_abort");
    abort_h = 1'b0;

    // Load ignored mid-loop, then abort with a load pending.
    alpctl_in_h = 10'h27C; alpctl_ld_h = 1'b1;
    tick("ign");
    alpctl_ld_h = 1'b0;
    repeat (22) tick("ign_loop");
    chk("ign.cnt10", 32'(step_cnt_h), 32'd10);
    alpctl_in_h = 10'h36A; alpctl_ld_h = 1'b1;
    tick("ign_ld");
    chk("ign.alpctl", 32'(alpctl_h), 32'h27C);
    chk("ign.cnt9",   32'(step_cnt_h), 32'd9);
    alpctl_ld_h = 1'b0;
    repeat (4) tick("ign_loop2");
    chk("abort.cnt5", 32'(step_cnt_h), 32'd5);
    alpctl_in_h = 10'h279; alpctl_ld_h = 1'b1; abort_h = 1'b1;
    tick("abort");
    chk("abort.alpctl", 32'(alpctl_h), 32'h000);
    chk("abort.busy",   32'(md_busy_h), 32'h0);
    chk("abort.cnt",    32'(step_cnt_h), 32'h0);
    chk("abort.stall",  32'(useq_stall_h), 32'h0);
    abort_h = 1'b0; alpctl_ld_h = 1'b0;

    // Asynchronous reset between edges during a loop.
    alpctl_in_h = 10'h269; alpctl_ld_h = 1'b1;
    tick("rst");
    alpctl_ld_h = 1'b0;
    repeat (5) tick("rst_loop");
    #3;
    reset_h = 1'b1;
    model_reset();
    #1;
    chk("rst.alpctl", 32'(alpctl_h), 32'h000);
    chk("rst.dec",    32'(dut_dec), 32'h7B);
    chk("rst.busy",   32'(md_busy_h), 32'h0);
    chk("rst.stall",  32'(useq_stall_h), 32'h0);
    chk("rst.cnt",    32'(step_cnt_h), 32'h0);
    #2;
    reset_h = 1'b0;

    // Every code loaded singly.
    for (int c = 0; c < 1024; c++) begin
      alpctl_in_h = 10'(c); alpctl_ld_h = 1'b1; abort_h = 1'b0;
      tick("sweep");
      chk("sweep.dec",  32'(dut_dec), 32'(ref_dec(c)));
      chk("sweep.busy", 32'(md_busy_h), 32'(ref_md(c)));
      alpctl_ld_h = 1'b0; abort_h = 1'b1;
      tick("sweep_abort");
      abort_h = 1'b0;
    end

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      abort_h     = ($urandom_range(0, 59) == 0);
      alpctl_ld_h = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0)
        alpctl_in_h = 10'(picks[$urandom_range(0, 11)]);
      else
        alpctl_in_h = 10'($urandom);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
